// File: rtl/cmat_sched.sv
// cmat_sched: round-robin job scheduler for a shared complex-matrix product/sort engine
module cmat_sched #(
    parameter int ENG_LAT = 20,
    parameter int TIMEOUT = 2 * ENG_LAT,
    parameter int BEATS   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       eng_start,
    input  logic       eng_done,
    output logic [1:0] res_idx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_id,
    output logic       out_last,
    output logic       busy,
    output logic       err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          cur_id_q, cur_id_d;
    logic          last_id_q, last_id_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    beat_q, beat_d;
    logic [1:0]    gnt_q, gnt_d, res_idx_q, res_idx_d;
    logic          eng_start_q, eng_start_d, out_valid_q, out_valid_d;
    logic          out_id_q, out_id_d, out_last_q, out_last_d;
    logic          busy_q, busy_d, err_q, err_d;

    // Next state; outputs are derived from the next state so every port comes straight from a flop
    always_comb begin
        state_d   = state_q;
        cur_id_d  = cur_id_q;
        last_id_d = last_id_q;
        timer_d   = timer_q;
        beat_d    = beat_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: if (|req) begin
                cur_id_d = (req == 2'b11) ? ~last_id_q : req[1];
                state_d  = GRANT;
            end
            GRANT: begin
                timer_d = '0;
                state_d = RUN;
            end
            RUN: begin
                timer_d = timer_q + 1'b1;
                if (eng_done) begin
                    beat_d  = '0;
                    state_d = DRAIN;
                end else if (timer_d == TW'(TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    last_id_d = cur_id_q;
                    state_d   = IDLE;
                end
            end
            default: if (out_ready) begin
                if (beat_q == 2'(BEATS - 1)) begin
                    last_id_d = cur_id_q;
                    state_d   = IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
        endcase
        gnt_d       = (state_d == GRANT) ? (cur_id_d ? 2'b10 : 2'b01) : 2'b00;
        eng_start_d = state_d == GRANT;
        out_valid_d = state_d == DRAIN;
        res_idx_d   = out_valid_d ? beat_d : 2'b00;
        out_id_d    = out_valid_d & cur_id_d;
        out_last_d  = out_valid_d && (beat_d == 2'(BEATS - 1));
        busy_d      = state_d != IDLE;
    end

    // State and output registers, forced to idle values asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_id_q    <= 1'b0;
            last_id_q   <= 1'b1;
            timer_q     <= '0;
            beat_q      <= '0;
            gnt_q       <= '0;
            eng_start_q <= 1'b0;
            res_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            last_id_q   <= last_id_d;
            timer_q     <= timer_d;
            beat_q      <= beat_d;
            gnt_q       <= gnt_d;
            eng_start_q <= eng_start_d;
            res_idx_q   <= res_idx_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign gnt       = gnt_q;
    assign eng_start = eng_start_q;
    assign res_idx   = res_idx_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign err       = err_q;
endmodule

// File: tb/tb_cmat_sched.sv
// tb_cmat_sched: transaction-level checks of cmat_sched arbitration, timeout, drain and reset
module tb_cmat_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] gnt;
    logic       eng_start;
    logic       eng_done = 1'b0;
    logic [1:0] res_idx;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_id;
    logic       out_last;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic model_last = 1'b1;

    cmat_sched dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .eng_start(eng_start),
        .eng_done(eng_done), .res_idx(res_idx), .out_valid(out_valid),
        .out_ready(out_ready), .out_id(out_id), .out_last(out_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_start"}, 32'(eng_start), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_idx"}, 32'(res_idx), 0);
        chk({tag, "_id"}, 32'(out_id), 0);
        chk({tag, "_last"}, 32'(out_last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        idle_outputs("rst");
        chk("rst_err", 32'(err), 0);
        #2;
        rst = 1'b0;
        model_last = 1'b1;
        step();
    endtask

    // mode: 0 random ready, 1 ready pattern 1,0,0,1,1, 2 reset at beat 1, 3 always ready; lat<0 means no eng_done
    task automatic job(input logic [1:0] r, input int lat, input int mode);
        int pat[5] = '{1, 0, 0, 1, 1};
        logic exp_id;
        int exp_beat;
        bit rdy, fin;
        exp_id = (r == 2'b11) ? ~model_last : r[1];
        req = r;
        step();
        chk("gnt", 32'(gnt), exp_id ? 2 : 1);
        chk("start", 32'(eng_start), 1);
        chk("busy_grant", 32'(busy), 1);
        req = 2'($urandom_range(0, 3));
        step();
        chk("gnt_run", 32'(gnt), 0);
        chk("start_run", 32'(eng_start), 0);
        if (lat < 0) begin
            for (int n = 2; n <= 40; n++) begin
                step();
                if (n == 39) chk("err_early", 32'(err), 0);
            end
            chk("err_pulse", 32'(err), 1);
            chk("busy_abort", 32'(busy), 0);
            chk("valid_abort", 32'(out_valid), 0);
            model_last = exp_id;
            req = 2'b00;
            step();
            chk("err_once", 32'(err), 0);
            chk("busy_after_abort", 32'(busy), 0);
            return;
        end
        for (int n = 1; n < lat; n++) step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("err_done", 32'(err), 0);
        exp_beat = 0;
        fin = 1'b0;
        for (int it = 0; it < 60 && !fin; it++) begin
            chk("valid", 32'(out_valid), 1);
            chk("res_idx", 32'(res_idx), 32'(exp_beat));
            chk("out_id", 32'(out_id), 32'(exp_id));
            chk("out_last", 32'(out_last), 32'(exp_beat == 2));
            chk("busy_drain", 32'(busy), 1);
            if (mode == 2 && exp_beat == 1) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_valid", 32'(out_valid), 0);
                chk("rst_busy", 32'(busy), 0);
                #1 rst = 1'b0;
                model_last = 1'b1;
                req = 2'b00;
                eng_done = 1'b1;
                step();
                eng_done = 1'b0;
                chk("late_done_busy", 32'(busy), 0);
                chk("late_done_valid", 32'(out_valid), 0);
                return;
            end
            rdy = (mode == 1) ? (it < 5 ? pat[it] != 0 : 1'b1) : (mode == 3) ? 1'b1 : 1'($urandom % 2);
            out_ready = rdy;
            eng_done = 1'($urandom % 2);
            step();
            out_ready = 1'b0;
            eng_done = 1'b0;
            if (rdy) begin
                if (exp_beat == 2) fin = 1'b1;
                else exp_beat++;
            end
        end
        chk("drain_finished", 32'(fin), 1);
        chk("valid_end", 32'(out_valid), 0);
        chk("last_end", 32'(out_last), 0);
        chk("busy_end", 32'(busy), 0);
        model_last = exp_id;
        req = 2'b00;
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("idle_done_ignored", 32'(busy), 0);
    endtask

    initial begin
        #3;
        idle_outputs("por");
        chk("por_err", 32'(err), 0);
        #20 rst = 1'b0;
        step();
        job(2'b11, 20, 0);
        job(2'b11, 5, 0);
        job(2'b11, 12, 0);
        job(2'b01, 20, 3);
        do_reset();
        job(2'b11, 20, 3);
        job(2'b11, -1, 0);
        job(2'b11, 7, 0);
        job(2'b10, 10, 1);
        job(2'b11, 39, 0);
        job(2'b11, 1, 0);
        job(2'b10, 9, 2);
        job(2'b11, 15, 0);
        job(2'b01, -1, 0);
        job(2'b11, 3, 0);
        for (int i = 0; i < 12; i++)
            job(2'($urandom_range(1, 3)), int'($urandom_range(1, 39)), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
